// File: rtl/pass_entry_ctrl_if.sv
// Keypad-to-controller bus for pass_entry_ctrl: key strobes and stored code in,
// password display and lock/alarm indications out.
interface pass_entry_ctrl_if;
  logic [11:0] i_stored_pass;
  logic        i_key_valid;
  logic [3:0]  i_key_digit;
  logic        i_key_clear;
  logic        i_key_enter;
  logic [11:0] o_password;
  logic        o_disp_en;
  logic        o_unlock;
  logic        o_alarm;
  logic        o_fail;

  modport master (
    output i_stored_pass, i_key_valid, i_key_digit, i_key_clear, i_key_enter,
    input  o_password, o_disp_en, o_unlock, o_alarm, o_fail
  );

  modport slave (
    input  i_stored_pass, i_key_valid, i_key_digit, i_key_clear, i_key_enter,
    output o_password, o_disp_en, o_unlock, o_alarm, o_fail
  );
endinterface

// File: rtl/pass_entry_ctrl.sv
// Door-code entry sequencer: collects 3 BCD digits, checks them on Enter, and
// drives unlock / fail-count lockout. Define PASS_LOCKOUT_BLINK_EN to flash the display during lockout.
module pass_entry_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned UNLOCK_CYCLES  = 500,
  parameter int unsigned MAX_FAIL       = 3,
  parameter int unsigned LOCKOUT_CYCLES = 2000,
  parameter int unsigned BLINK_CYCLES   = 50
) (
  input  logic              i_clk,
  input  logic              i_rst,
  pass_entry_ctrl_if.slave  bus
);

  localparam int unsigned HOLD_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned TMO_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX) + 1;
  localparam int unsigned FAIL_W   = $clog2(MAX_FAIL) + 1;

  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, OPEN, LOCKOUT} state_t;

  state_t              state;
  logic [1:0]          digit_cnt;
  logic [FAIL_W-1:0]   fail_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
`ifdef PASS_LOCKOUT_BLINK_EN
  localparam int unsigned BLINK_W = $clog2(BLINK_CYCLES) + 1;
  logic [BLINK_W-1:0]  blink_cnt;
`endif

  // Digit strobe that survives priority: clear and enter both outrank it.
  logic digit_ok;
  assign digit_ok = bus.i_key_valid && (bus.i_key_digit <= 4'd9)
                    && !bus.i_key_clear && !bus.i_key_enter;

  // NOTE: non-blocking assignments only; every branch reads pre-edge register values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= IDLE;
      digit_cnt      <= '0;
      fail_cnt       <= '0;
      tmo_cnt        <= '0;
      hold_cnt       <= '0;
      bus.o_password <= '0;
      bus.o_disp_en  <= 1'b0;
      bus.o_unlock   <= 1'b0;
      bus.o_alarm    <= 1'b0;
      bus.o_fail     <= 1'b0;
`ifdef PASS_LOCKOUT_BLINK_EN
      blink_cnt      <= '0;
`endif
    end else begin
      bus.o_fail <= 1'b0;
      case (state)
        IDLE: begin
          if (digit_ok) begin
            state          <= ENTRY;
            bus.o_password <= {8'h00, bus.i_key_digit};
            digit_cnt      <= 2'd1;
            tmo_cnt        <= '0;
            bus.o_disp_en  <= 1'b1;
          end
        end

        ENTRY: begin
          if (bus.i_key_clear) begin
            state          <= IDLE;
            bus.o_password <= '0;
            digit_cnt      <= '0;
            bus.o_disp_en  <= 1'b0;
          end else if (bus.i_key_enter && digit_cnt == 2'd3) begin
            state <= CHECK;
          end else if (digit_ok && digit_cnt != 2'd3) begin
            bus.o_password <= {bus.o_password[7:0], bus.i_key_digit};
            digit_cnt      <= digit_cnt + 2'd1;
            tmo_cnt        <= '0;
          end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state          <= IDLE;
            bus.o_password <= '0;
            digit_cnt      <= '0;
            bus.o_disp_en  <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        CHECK: begin
          digit_cnt <= '0;
          hold_cnt  <= '0;
          if (bus.o_password == bus.i_stored_pass) begin
            state          <= OPEN;
            fail_cnt       <= '0;
            bus.o_password <= '0;
            bus.o_unlock   <= 1'b1;
            bus.o_disp_en  <= 1'b0;
          end else begin
            bus.o_fail <= 1'b1;
            fail_cnt   <= fail_cnt + 1'b1;
            if (fail_cnt + 1'b1 == FAIL_W'(MAX_FAIL)) begin
              // Rejected code stays on the bus so the blink build can flash it.
              state       <= LOCKOUT;
              bus.o_alarm <= 1'b1;
`ifdef PASS_LOCKOUT_BLINK_EN
              bus.o_disp_en <= 1'b1;
              blink_cnt     <= '0;
`else
              bus.o_disp_en <= 1'b0;
`endif
            end else begin
              state          <= IDLE;
              bus.o_password <= '0;
              bus.o_disp_en  <= 1'b0;
            end
          end
        end

        OPEN: begin
          if (hold_cnt == HOLD_W'(UNLOCK_CYCLES - 1)) begin
            state        <= IDLE;
            bus.o_unlock <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        LOCKOUT: begin
`ifdef PASS_LOCKOUT_BLINK_EN
          if (blink_cnt == BLINK_W'(BLINK_CYCLES - 1)) begin
            blink_cnt     <= '0;
            bus.o_disp_en <= ~bus.o_disp_en;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
`endif
          // Expiry assignments come last so they override the blink toggle.
          if (hold_cnt == HOLD_W'(LOCKOUT_CYCLES - 1)) begin
            state          <= IDLE;
            bus.o_alarm    <= 1'b0;
            bus.o_password <= '0;
            bus.o_disp_en  <= 1'b0;
            fail_cnt       <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pass_entry_ctrl.sv
// Directed bench for pass_entry_ctrl: entry, unlock, lockout, priority, timeout and reset.
module tb_pass_entry_ctrl;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  pass_entry_ctrl_if bus ();

  pass_entry_ctrl dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic key(input logic [3:0] d);
    bus.i_key_valid = 1'b1;
    bus.i_key_digit = d;
    tick();
    bus.i_key_valid = 1'b0;
  endtask

  // Enter a 3-digit code and stop at the cycle where unlock/fail becomes visible.
  task automatic submit(input logic [11:0] code);
    key(code[11:8]);
    key(code[7:4]);
    key(code[3:0]);
    bus.i_key_enter = 1'b1;
    tick();
    bus.i_key_enter = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    logic pw_bad;
    logic [3:0] blink_seen;
    logic [3:0] blink_exp;

    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.i_stored_pass = 12'h472;
    bus.i_key_valid   = 1'b0;
    bus.i_key_digit   = 4'd0;
    bus.i_key_clear   = 1'b0;
    bus.i_key_enter   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_password", bus.o_password, 12'h000);
    check("reset_outputs", {bus.o_disp_en, bus.o_unlock, bus.o_alarm, bus.o_fail}, 4'b0000);

    // Correct code opens the lock for exactly 500 cycles; keys are ignored while open.
    key(4'd4);
    check("first_digit", bus.o_password, 12'h004);
    check("entry_disp_en", bus.o_disp_en, 1'b1);
    key(4'd7);
    key(4'd2);
    check("code_before_enter", bus.o_password, 12'h472);
    bus.i_key_enter = 1'b1;
    tick();
    bus.i_key_enter = 1'b0;
    check("unlock_not_at_check", bus.o_unlock, 1'b0);
    tick();
    check("unlock_at_n_plus_2", bus.o_unlock, 1'b1);
    check("open_password_cleared", bus.o_password, 12'h000);
    n = 0;
    for (int i = 0; i < 600 && bus.o_unlock; i++) begin
      n++;
      bus.i_key_valid = (i == 10);
      bus.i_key_digit = 4'd5;
      tick();
    end
    bus.i_key_valid = 1'b0;
    check("unlock_length", n, 500);
    check("after_open_password", bus.o_password, 12'h000);
    check("after_open_disp_en", bus.o_disp_en, 1'b0);

    // Fourth digit dropped; Enter with two digits does nothing.
    key(4'd1);
    key(4'd2);
    key(4'd3);
    key(4'd4);
    check("fourth_digit_ignored", bus.o_password, 12'h123);
    bus.i_key_clear = 1'b1;
    tick();
    bus.i_key_clear = 1'b0;
    check("clear_password", bus.o_password, 12'h000);
    key(4'd1);
    key(4'd2);
    bus.i_key_enter = 1'b1;
    tick();
    bus.i_key_enter = 1'b0;
    tick();
    check("short_enter_password", bus.o_password, 12'h012);
    check("short_enter_outputs", {bus.o_disp_en, bus.o_unlock, bus.o_fail}, 3'b100);

    // Clear outranks a same-cycle digit.
    bus.i_key_clear = 1'b1;
    bus.i_key_valid = 1'b1;
    bus.i_key_digit = 4'd5;
    tick();
    bus.i_key_clear = 1'b0;
    bus.i_key_valid = 1'b0;
    check("clear_beats_digit_pw", bus.o_password, 12'h000);
    check("clear_beats_digit_disp", bus.o_disp_en, 1'b0);
    key(4'd6);
    check("restart_from_idle", bus.o_password, 12'h006);

    // Enter outranks a same-cycle digit; wrong code pulses o_fail (fail 1 of 3).
    key(4'd7);
    key(4'd8);
    bus.i_key_enter = 1'b1;
    bus.i_key_valid = 1'b1;
    bus.i_key_digit = 4'd9;
    tick();
    bus.i_key_enter = 1'b0;
    bus.i_key_valid = 1'b0;
    check("enter_beats_digit", bus.o_password, 12'h678);
    tick();
    check("fail1_pulse", bus.o_fail, 1'b1);
    check("fail1_password", bus.o_password, 12'h000);
    tick();
    check("fail_one_cycle", bus.o_fail, 1'b0);

    submit(12'h111);
    check("fail2_pulse", bus.o_fail, 1'b1);
    check("fail2_no_alarm", bus.o_alarm, 1'b0);
    submit(12'h111);
    check("fail3_pulse", bus.o_fail, 1'b1);
    check("fail3_alarm", bus.o_alarm, 1'b1);
    check("lockout_pw_held", bus.o_password, 12'h111);

    // Lockout: alarm for 2000 cycles, keys ignored, rejected code held.
    n = 0;
    pw_bad = 1'b0;
    blink_seen = '0;
    for (int i = 0; i < 2500 && bus.o_alarm; i++) begin
      n++;
      if (bus.o_password !== 12'h111) pw_bad = 1'b1;
      if (i == 0)   blink_seen[0] = bus.o_disp_en;
      if (i == 49)  blink_seen[1] = bus.o_disp_en;
      if (i == 50)  blink_seen[2] = bus.o_disp_en;
      if (i == 100) blink_seen[3] = bus.o_disp_en;
      bus.i_key_valid = (i == 30 || i == 31);
      bus.i_key_digit = 4'd5;
      bus.i_key_clear = (i == 40);
      bus.i_key_enter = (i == 41);
      tick();
    end
    bus.i_key_valid = 1'b0;
    bus.i_key_clear = 1'b0;
    bus.i_key_enter = 1'b0;
`ifdef PASS_LOCKOUT_BLINK_EN
    blink_exp = 4'b1011;
`else
    blink_exp = 4'b0000;
`endif
    check("alarm_length", n, 2000);
    check("lockout_keys_ignored", pw_bad, 1'b0);
    check("lockout_disp_pattern", blink_seen, blink_exp);
    check("after_lockout_pw", bus.o_password, 12'h000);
    check("after_lockout_outputs", {bus.o_disp_en, bus.o_alarm}, 2'b00);

    // Fail count restarted: two misses no alarm, third locks out again.
    submit(12'h111);
    check("post_lock_fail1", {bus.o_fail, bus.o_alarm}, 2'b10);
    submit(12'h111);
    check("post_lock_fail2", {bus.o_fail, bus.o_alarm}, 2'b10);
    submit(12'h111);
    check("post_lock_fail3", {bus.o_fail, bus.o_alarm}, 2'b11);
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_mid_lockout", {bus.o_alarm, bus.o_disp_en}, 2'b00);
    check("reset_mid_lockout_pw", bus.o_password, 12'h000);

    // Inactivity timeout, restarted by an accepted digit; invalid digit in IDLE ignored.
    key(4'd9);
    repeat (500) tick();
    key(4'd8);
    check("timeout_second_digit", bus.o_password, 12'h098);
    n = 0;
    while (bus.o_disp_en && n < 1100) begin
      tick();
      n++;
    end
    check("timeout_cycles", n, 1000);
    check("timeout_password", bus.o_password, 12'h000);
    key(4'd12);
    check("invalid_digit_idle", {bus.o_disp_en, bus.o_password}, 13'h0000);

    // Reset in the middle of OPEN.
    submit(12'h472);
    check("second_unlock", bus.o_unlock, 1'b1);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_mid_open", bus.o_unlock, 1'b0);
    tick();
    check("idle_after_reset", {bus.o_unlock, bus.o_disp_en, bus.o_password}, 14'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
